score_lockout_ctrl: RTL and testbench

Clocked, parametrised multi-player score controller for the game panel. It takes N active-low push buttons and enforces first-press-wins lockout: while one player's button is held, every other button is ignored. It keeps a per-player decimal score and drives one common-anode 7-segment digit per player. It replaces the two-player combinational score logic with synchronised, debounced, reset-safe sequential behaviour.

---
 rtl/game_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/score_lockout_ctrl.sv | 148 ++++++++++++++
 tb/tb_score_lockout_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and the 7-segment decode for the score/lockout controller.
package game_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Common-anode digit patterns, bit order g f e d c b a, 0 = lit.
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anything that is not a decimal digit blanks the display.
  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    if (val <= 4'd9) return SEG_LUT[val];
    else             return SEG_BLANK;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, level debouncer and edge pulses.
// The debounced level follows the synchronised input only after
// DEBOUNCE_CYCLES consecutive samples that disagree with it.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic level,
  output logic fall,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchroniser; idles at 1 so a released button never looks pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
    end
  end

  // Count disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      fall <= 1'b0;
      rise <= 1'b0;
      if (sync2 != level) begin
        if (cnt == TC) begin
          level <= sync2;
          cnt   <= '0;
          fall  <= ~sync2;
          rise  <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/score_lockout_ctrl.sv
// First-press-wins lockout with per-player decimal scores and digit drive.
//
//   state  | meaning
//   IDLE   | no player holds the lock; the lowest-index press wins it
//   LOCKED | owner holds the lock; other presses are dropped, not queued
module score_lockout_ctrl
  import game_pkg::*;
#(
  parameter int N_PLAYERS       = 2,
  parameter int MAX_SCORE       = 9,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WRAP            = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_PLAYERS-1:0]   btn_n,
  input  logic                   clear_n,
  output logic [4*N_PLAYERS-1:0] score,
  output logic [7*N_PLAYERS-1:0] seg_n,
  output logic [2:0]             owner,
  output logic                   locked,
  output logic                   score_evt
);

  logic [N_PLAYERS-1:0] lvl;
  logic [N_PLAYERS-1:0] fall;
  logic [N_PLAYERS-1:0] rise;
  logic                 clr_lvl;
  logic                 clr_fall;
  logic                 clr_rise;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_n (btn_n[g]),
      .level (lvl[g]),
      .fall  (fall[g]),
      .rise  (rise[g])
    );
  end

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (clear_n),
    .level (clr_lvl),
    .fall  (clr_fall),
    .rise  (clr_rise)
  );

  lock_state_t                 state;
  lock_state_t                 state_nx;
  logic [2:0]                  owner_nx;
  logic                        grant;
  logic [2:0]                  grant_idx;
  logic                        owner_rise;
  logic                        win;
  logic                        clear_hold;
  logic [N_PLAYERS-1:0][3:0]   score_q;
  logic [N_PLAYERS-1:0][3:0]   score_nx;
  logic [N_PLAYERS-1:0][6:0]   seg_q;
  logic [N_PLAYERS-1:0][6:0]   seg_nx;

  assign clear_hold = ~clr_lvl;
  assign locked     = (state == LOCKED);
  assign score      = score_q;
  assign seg_n      = seg_q;

  function automatic logic [3:0] bump(input logic [3:0] s);
    if (s < 4'(MAX_SCORE)) return s + 4'd1;
    else if (WRAP != 0)    return 4'd0;
    else                   return s;
  endfunction

  // Priority encoder: lowest-index press wins; owner's release select.
  always_comb begin
    grant      = 1'b0;
    grant_idx  = 3'd0;
    owner_rise = 1'b0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (fall[i]) begin
        grant     = 1'b1;
        grant_idx = 3'(i);
      end
    end
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (owner == 3'(i)) owner_rise = rise[i];
    end
  end

  // Lockout next-state; presses arriving while locked are simply dropped.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    win      = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nx = LOCKED;
          owner_nx = grant_idx;
          win      = 1'b1;
        end
      end
      LOCKED: begin
        if (owner_rise) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next score and its digit; held clear overrides any same-cycle win.
  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      score_nx[i] = score_q[i];
      if (clear_hold)
        score_nx[i] = 4'd0;
      else if (win && (grant_idx == 3'(i)))
        score_nx[i] = bump(score_q[i]);
      seg_nx[i] = seg_decode(score_nx[i]);
    end
  end

  // FSM state and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 3'd0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
    end
  end

  // Score, digit and event registers, updated together so they stay coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q   <= '0;
      seg_q     <= {N_PLAYERS{SEG_LUT[0]}};
      score_evt <= 1'b0;
    end else begin
      score_q   <= score_nx;
      seg_q     <= seg_nx;
      score_evt <= win & ~clear_hold;
    end
  end

endmodule

// File: tb/tb_score_lockout_ctrl.sv
// Scoreboard bench: stimulus pushes predicted scoring events, a negedge
// monitor pops them whenever score_evt fires. Two DUTs share stimulus,
// one saturating and one wrapping.
module tb_score_lockout_ctrl;

  localparam int N = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_n;
  logic         clear_n;

  logic [4*N-1:0] score_s, score_w;
  logic [7*N-1:0] seg_s, seg_w;
  logic [2:0]     owner_s, owner_w;
  logic           locked_s, locked_w, evt_s, evt_w;

  always #5 clk = ~clk;

  score_lockout_ctrl #(.N_PLAYERS(N), .MAX_SCORE(9), .DEBOUNCE_CYCLES(D), .WRAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .clear_n(clear_n),
    .score(score_s), .seg_n(seg_s), .owner(owner_s), .locked(locked_s), .score_evt(evt_s));

  score_lockout_ctrl #(.N_PLAYERS(N), .MAX_SCORE(9), .DEBOUNCE_CYCLES(D), .WRAP(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .clear_n(clear_n),
    .score(score_w), .seg_n(seg_w), .owner(owner_w), .locked(locked_w), .score_evt(evt_w));

  typedef struct {
    int p;
    int s_sat;
    int s_wrap;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         m_sat[N];
  int         m_wrap[N];
  bit         m_clear = 1'b0;
  bit         mon_en = 1'b0;
  logic [6:0] seg_ref [0:15];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a scoring press bumps the winner, unless clear is held.
  task automatic model_press(input int p);
    exp_t e;
    if (!m_clear) begin
      m_sat[p]  = (m_sat[p] < 9) ? m_sat[p] + 1 : 9;
      m_wrap[p] = (m_wrap[p] < 9) ? m_wrap[p] + 1 : 0;
      e.p = p; e.s_sat = m_sat[p]; e.s_wrap = m_wrap[p];
      exp_q.push_back(e);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < N; i++) begin
      m_sat[i]  = 0;
      m_wrap[i] = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: digits always track scores; every event must match a prediction.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("seg_sat_%0d", i), int'(seg_s[7*i +: 7]), int'(seg_ref[score_s[4*i +: 4]]));
        check($sformatf("seg_wrap_%0d", i), int'(seg_w[7*i +: 7]), int'(seg_ref[score_w[4*i +: 4]]));
      end
      check("evt_agree", int'(evt_w), int'(evt_s));
      if (evt_s) begin
        if (exp_q.size() == 0) begin
          check("evt_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("evt_owner", int'(owner_s), e.p);
          check("evt_locked", int'(locked_s), 1);
          check("evt_score_sat", int'(score_s[4*e.p +: 4]), e.s_sat);
          check("evt_score_wrap", int'(score_w[4*e.p +: 4]), e.s_wrap);
        end
      end
    end
  end

  task automatic drain_check();
    check("queue_drain", exp_q.size(), 0);
  endtask

  task automatic op_single(input int p, input int hold);
    btn_n[p] = 1'b0;
    model_press(p);
    tick(hold);
    btn_n[p] = 1'b1;
    tick(20);
    drain_check();
  endtask

  task automatic op_overlap(input int a, input int tail);
    int b;
    b = 1 - a;
    btn_n[a] = 1'b0;
    model_press(a);
    tick(10);
    btn_n[b] = 1'b0;
    tick(20);
    btn_n[a] = 1'b1;
    tick(tail);
    btn_n[b] = 1'b1;
    tick(20);
    drain_check();
  endtask

  task automatic op_simul(input int hold);
    btn_n = '0;
    model_press(0);
    tick(hold);
    btn_n = '1;
    tick(20);
    drain_check();
  endtask

  task automatic op_glitch(input int p);
    for (int k = 0; k < 5; k++) begin
      btn_n[p] = 1'b0;
      tick($urandom_range(1, D - 1));
      btn_n[p] = 1'b1;
      tick($urandom_range(1, 3));
    end
    tick(20);
    drain_check();
  endtask

  task automatic op_clear(input int p);
    clear_n = 1'b0;
    tick(10);
    m_clear = 1'b1;
    model_zero();
    check("clear_zero_0", int'(score_s[3:0]), 0);
    check("clear_zero_1", int'(score_w[7:4]), 0);
    btn_n[p] = 1'b0;
    model_press(p);
    tick(12);
    btn_n[p] = 1'b1;
    tick(15);
    check("clear_press_p", int'(score_s[4*p +: 4]), 0);
    clear_n = 1'b1;
    tick(20);
    m_clear = 1'b0;
    drain_check();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) seg_ref[i] = 7'b1111111;
    seg_ref[0] = 7'b1000000; seg_ref[1] = 7'b1111001; seg_ref[2] = 7'b0100100;
    seg_ref[3] = 7'b0110000; seg_ref[4] = 7'b0011001; seg_ref[5] = 7'b0010010;
    seg_ref[6] = 7'b0000010; seg_ref[7] = 7'b1111000; seg_ref[8] = 7'b0000000;
    seg_ref[9] = 7'b0010000;
    model_zero();

    rst_n = 1'b0; btn_n = '1; clear_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check("rst_score", int'(score_s), 0);
    check("rst_seg", int'(seg_s), int'({7'b1000000, 7'b1000000}));
    check("rst_locked", int'(locked_s), 0);
    check("rst_owner", int'(owner_s), 0);
    check("rst_evt", int'(evt_s), 0);
    mon_en = 1'b1;

    // Press latency: outputs move on the 7th edge, not the 6th.
    btn_n[0] = 1'b0;
    model_press(0);
    repeat (6) @(posedge clk);
    #1;
    check("lat_evt_early", int'(evt_s), 0);
    check("lat_locked_early", int'(locked_s), 0);
    check("lat_score_early", int'(score_s[3:0]), 0);
    @(posedge clk);
    #1;
    check("lat_evt", int'(evt_s), 1);
    check("lat_locked", int'(locked_s), 1);
    check("lat_score", int'(score_s[3:0]), 1);
    tick(13);
    btn_n[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rel_locked_early", int'(locked_s), 1);
    @(posedge clk);
    #1;
    check("rel_locked", int'(locked_s), 0);
    tick(15);
    drain_check();

    // Lockout and simultaneous presses.
    op_overlap(0, 3);
    op_single(1, 15);
    op_simul(15);

    // Bounce: toggle every two cycles for 20 cycles.
    for (int k = 0; k < 5; k++) begin
      btn_n[1] = 1'b0; tick(2);
      btn_n[1] = 1'b1; tick(2);
    end
    tick(20);
    check("bounce_score1", int'(score_s[7:4]), m_sat[1]);
    drain_check();

    // Build scores 3/5, then clear during a lock.
    op_clear(0);
    for (int k = 0; k < 3; k++) op_single(0, 10);
    for (int k = 0; k < 5; k++) op_single(1, 10);
    check("pre_clear_0", int'(score_s[3:0]), 3);
    check("pre_clear_1", int'(score_s[7:4]), 5);
    btn_n[0] = 1'b0;
    model_press(0);
    tick(10);
    clear_n = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    m_clear = 1'b1;
    model_zero();
    check("clear_lock_0", int'(score_s[3:0]), 0);
    check("clear_lock_1", int'(score_s[7:4]), 0);
    check("clear_lock_held", int'(locked_s), 1);
    tick(5);
    btn_n[0] = 1'b1;
    tick(20);
    clear_n = 1'b1;
    tick(20);
    m_clear = 1'b0;
    drain_check();
    op_single(0, 10);
    check("post_clear", int'(score_s[3:0]), 1);

    // Saturate vs wrap on player 1.
    for (int k = 0; k < 10; k++) op_single(1, 10);
    check("sat_final", int'(score_s[7:4]), 9);
    check("wrap_final", int'(score_w[7:4]), 0);

    // Reset mid-lock, button still held afterwards counts as a press.
    btn_n[1] = 1'b0;
    model_press(1);
    tick(12);
    rst_n = 1'b0;
    #1;
    check("mid_rst_score", int'(score_s), 0);
    check("mid_rst_locked", int'(locked_s), 0);
    check("mid_rst_seg", int'(seg_w), int'({7'b1000000, 7'b1000000}));
    check("mid_rst_owner", int'(owner_s), 0);
    exp_q.delete();
    model_zero();
    tick(3);
    rst_n = 1'b1;
    model_press(1);
    tick(15);
    btn_n[1] = 1'b1;
    tick(20);
    drain_check();

    // Randomized operation mix.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: op_single($urandom_range(0, 1), $urandom_range(8, 25));
        1: op_overlap($urandom_range(0, 1), $urandom_range(1, 15));
        2: op_simul($urandom_range(8, 20));
        3: op_glitch($urandom_range(0, 1));
        default: begin
          if ($urandom_range(0, 3) == 0) op_clear($urandom_range(0, 1));
          else op_single($urandom_range(0, 1), $urandom_range(8, 25));
        end
      endcase
    end

    tick(30);
    for (int i = 0; i < N; i++) begin
      check($sformatf("final_sat_%0d", i), int'(score_s[4*i +: 4]), m_sat[i]);
      check($sformatf("final_wrap_%0d", i), int'(score_w[4*i +: 4]), m_wrap[i]);
    end
    drain_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
